// File: rtl/branch_pred_unit.sv
// branch_pred_unit: IF-stage dynamic branch prediction from a direct-mapped
// table of 2-bit counters, tags and targets, plus EX-stage branch resolution
// with mispredict/redirect generation, table update and perf counters.
module branch_pred_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [2:0]        branch,
    input  logic              less,
    input  logic              zero,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic              pc_asrc,
    output logic              pc_bsrc,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [2:0] BR_NO       = 3'd0;
    localparam logic [2:0] BR_JUMP_PC  = 3'd1;
    localparam logic [2:0] BR_JUMP_REG = 3'd2;
    localparam logic [2:0] BR_EQ       = 3'd4;
    localparam logic [2:0] BR_UEQ      = 3'd5;
    localparam logic [2:0] BR_LT       = 3'd6;
    localparam logic [2:0] BR_GT       = 3'd7;

    localparam logic [XLEN-1:0]   PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    // Prediction table state
    logic              valid_q [BHT_DEPTH];
    logic              valid_d [BHT_DEPTH];
    logic [1:0]        cnt_q   [BHT_DEPTH];
    logic [1:0]        cnt_d   [BHT_DEPTH];
    logic [TAG_W-1:0]  tag_q   [BHT_DEPTH];
    logic [TAG_W-1:0]  tag_d   [BHT_DEPTH];
    logic [XLEN-1:0]   tgt_q   [BHT_DEPTH];
    logic [XLEN-1:0]   tgt_d   [BHT_DEPTH];

    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_mp_q, perf_mp_d;

    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    logic              if_hit;
    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic              ex_hit;
    logic              taken;
    logic              writable;
    logic              upd_en;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

    // IF lookup: sees registered table contents only, so a same-cycle update is not visible yet
    always_comb begin
        if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken = 1'b0;
        if (!rst) begin
            pred_taken = if_hit && cnt_q[if_idx][1];
        end else begin
            pred_taken = 1'b0;
        end
        pred_target = pred_taken ? tgt_q[if_idx] : (if_pc + PC_STEP);
    end

    // EX resolution: decode the branch code into taken/selects and flag mispredicts
    always_comb begin
        taken    = 1'b0;
        pc_bsrc  = 1'b0;
        writable = 1'b0;
        case (branch)
            BR_NO:       begin taken = 1'b0;  writable = 1'b0; end
            BR_JUMP_PC:  begin taken = 1'b1;  writable = 1'b1; end
            BR_JUMP_REG: begin taken = 1'b1;  pc_bsrc = 1'b1; writable = 1'b0; end
            BR_EQ:       begin taken = zero;  writable = 1'b1; end
            BR_UEQ:      begin taken = ~zero; writable = 1'b1; end
            BR_LT:       begin taken = less;  writable = 1'b1; end
            BR_GT:       begin taken = ~less; writable = 1'b1; end
            default:     begin taken = 1'b0;  writable = 1'b0; end
        endcase
        if (rst || !ex_valid) begin
            taken      = 1'b0;
            pc_bsrc    = 1'b0;
            writable   = 1'b0;
            mispredict = 1'b0;
        end else begin
            mispredict = (branch != BR_NO) &&
                         ((taken != ex_pred_taken) ||
                          (taken && (ex_target != ex_pred_target)));
        end
        pc_asrc     = taken;
        redirect_pc = taken ? ex_target : (ex_pc + PC_STEP);
    end

    // Table update: train the counter on a hit, allocate on a taken miss
    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        upd_en  = writable;
        if (upd_en) begin
            if (ex_hit) begin
                if (taken) begin
                    cnt_d[ex_idx] = (cnt_q[ex_idx] == 2'b11) ? 2'b11 : (cnt_q[ex_idx] + 2'b01);
                    tgt_d[ex_idx] = ex_target;
                end else begin
                    cnt_d[ex_idx] = (cnt_q[ex_idx] == 2'b00) ? 2'b00 : (cnt_q[ex_idx] - 2'b01);
                end
            end else if (taken) begin
                valid_d[ex_idx] = 1'b1;
                tag_d[ex_idx]   = ex_tag;
                tgt_d[ex_idx]   = ex_target;
                cnt_d[ex_idx]   = (branch == BR_JUMP_PC) ? 2'b11 : 2'b10;
            end else begin
                valid_d[ex_idx] = valid_q[ex_idx];
            end
        end else begin
            valid_d[ex_idx] = valid_q[ex_idx];
        end
    end

    // Perf counter next values; they wrap naturally at 2^PERF_W
    always_comb begin
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (ex_valid && (branch != BR_NO)) begin
            perf_br_d = perf_br_q + PERF_ONE;
        end else begin
            perf_br_d = perf_br_q;
        end
        if (mispredict) begin
            perf_mp_d = perf_mp_q + PERF_ONE;
        end else begin
            perf_mp_d = perf_mp_q;
        end
    end

    // State registers with synchronous reset; reset discards any same-cycle EX update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b01;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
            end
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            tgt_q     <= tgt_d;
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;

endmodule
